// File: rtl/bram_rd_pkg.sv
// Shared constants and FSM encoding for the block RAM stream reader.
// RAM geometry is fixed here so every file agrees on address and word widths.
package bram_rd_pkg;

   localparam int ADDR_W = 11;
   localparam int DATA_W = 16;
   localparam int LEN_W  = 12;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN
   } rd_state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Valid/ready output stream carrying RAM words plus an end-of-command marker.
interface bram_stream_reader_if;
   import bram_rd_pkg::*;

   logic              m_valid;
   logic              m_ready;
   logic [DATA_W-1:0] m_data;
   logic              m_last;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface

// File: rtl/bram_rd_fifo.sv
// Shift-register FIFO whose head entry is a register, so a word pushed at one
// edge is presented on the output right after that edge.
module bram_rd_fifo #(
   parameter int WIDTH = 17,
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             valid,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   localparam int IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] entry_q [DEPTH];
   logic [CNT_W-1:0] count_q;
   logic [IDX_W-1:0] wr_idx;
   logic             do_pop;

   assign do_pop = pop & valid;
   assign valid  = (count_q != '0);
   assign dout   = entry_q[0];
   assign count  = count_q;
   assign wr_idx = IDX_W'(count_q - CNT_W'(do_pop));

   // A pop shifts everything toward the head; a simultaneous push lands in
   // the first free slot after that shift, so it overrides the shifted value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            entry_q[i] <= '0;
         end
         count_q <= '0;
      end else begin
         if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
               entry_q[i] <= entry_q[i+1];
            end
         end
         if (push) begin
            entry_q[wr_idx] <= din;
         end
         count_q <= count_q + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/bram_stream_reader.sv
// Walks an address window of the block RAM and streams the returned words out
// through a small FIFO, issuing reads only when buffer space is guaranteed.
module bram_stream_reader
   import bram_rd_pkg::*;
#(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [LEN_W-1:0]     length,
   output logic                 busy,
   output logic                 done,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   input  logic [DATA_W-1:0]    mem_dout,
   bram_stream_reader_if.master strm
);

   localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int CRED_W = CNT_W + 1;

   rd_state_t         state, next_state;
   logic [ADDR_W-1:0] addr_q, issue_addr;
   logic [LEN_W-1:0]  remaining_q, len_q, beat_cnt;
   logic [1:0]        tag_q;
   logic [CNT_W-1:0]  fifo_count;
   logic [CRED_W-1:0] committed;
   logic [DATA_W:0]   fifo_dout;
   logic              issue, zero_cmd, pop, push, push_last, credit_ok, last_pop;

   assign pop        = strm.m_valid & strm.m_ready;
   assign last_pop   = pop & strm.m_last;
   assign push       = tag_q[1];
   assign push_last  = (beat_cnt == len_q - LEN_W'(1));
   assign issue_addr = (state == IDLE) ? base_addr : addr_q;
   assign busy       = (state != IDLE);
   assign mem_we     = 1'b0;

   // Words already buffered plus reads still in the RAM pipe; a freeing pop
   // this cycle buys one extra slot so issue never outruns the FIFO.
   assign committed = CRED_W'(fifo_count) + CRED_W'(tag_q[0]) + CRED_W'(tag_q[1]);
   assign credit_ok = committed < (CRED_W'(FIFO_DEPTH) + CRED_W'(pop));

   // The first read goes out on the accepting edge itself, which is what makes
   // the first beat appear three cycles after the start strobe.
   always_comb begin
      next_state = state;
      issue      = 1'b0;
      zero_cmd   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               if (length == '0) begin
                  zero_cmd = 1'b1;
               end else begin
                  issue      = 1'b1;
                  next_state = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (remaining_q == '0) begin
               next_state = DRAIN;
            end else if (credit_ok) begin
               issue = 1'b1;
               if (remaining_q == LEN_W'(1)) begin
                  next_state = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (last_pop) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         addr_q      <= '0;
         mem_addr    <= '0;
         remaining_q <= '0;
         len_q       <= '0;
         beat_cnt    <= '0;
         tag_q       <= '0;
         done        <= 1'b0;
      end else begin
         state <= next_state;
         tag_q <= {tag_q[0], issue};
         done  <= zero_cmd | ((state == DRAIN) & last_pop);
         if (issue) begin
            mem_addr <= issue_addr;
            addr_q   <= issue_addr + ADDR_W'(1);
         end
         if ((state == IDLE) && issue) begin
            len_q       <= length;
            remaining_q <= length - LEN_W'(1);
            beat_cnt    <= '0;
         end else begin
            if (issue) begin
               remaining_q <= remaining_q - LEN_W'(1);
            end
            if (push) begin
               beat_cnt <= beat_cnt + LEN_W'(1);
            end
         end
      end
   end

   bram_rd_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .din   ({push_last, mem_dout}),
      .pop   (pop),
      .valid (strm.m_valid),
      .dout  (fifo_dout),
      .count (fifo_count)
   );

   assign strm.m_data = fifo_dout[DATA_W-1:0];
   assign strm.m_last = fifo_dout[DATA_W];

endmodule
